// File: rtl/imem_loadable.sv
// Loadable instruction memory: a program is streamed in over a valid/ready
// port, then fetched through a registered port; unloaded words read as halt.
module imem_loadable #(
    parameter int            IW        = 9,
    parameter int            AW        = 8,
    parameter logic [IW-1:0] HALT_INST = {IW{1'b1}}
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          run,
    input  logic [AW-1:0] PC,
    input  logic          fetch_en,
    output logic [IW-1:0] inst,
    output logic [AW:0]   prog_len,
    output logic [IW-1:0] checksum,
    output logic          load_full
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [AW-1:0]     wptr;
    logic              accept;
    logic              at_end;

    assign load_ready = (state == LOAD);
    assign run        = (state == RUN);
    assign accept     = load_ready && load_valid && !load_start;
    // Words are stored densely from 0, so the count doubles as write pointer.
    assign wptr       = prog_len[AW-1:0];
    assign at_end     = &wptr;

    always_comb begin
        state_nxt = state;
        if (load_start) begin
            state_nxt = LOAD;
        end else if (accept && (load_last || at_end)) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            valid     <= '0;
            prog_len  <= '0;
            checksum  <= '0;
            load_full <= 1'b0;
        end else if (load_start) begin
            valid     <= '0;
            prog_len  <= '0;
            checksum  <= '0;
            load_full <= 1'b0;
        end else if (accept) begin
            valid[wptr] <= 1'b1;
            prog_len    <= prog_len + {{AW{1'b0}}, 1'b1};
            checksum    <= checksum ^ load_data;
            if (at_end) begin
                load_full <= 1'b1;
            end
        end
    end

    // Array itself needs no reset: the valid bits gate every read.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wptr] <= load_data;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            inst <= HALT_INST;
        end else if (fetch_en) begin
            inst <= (run && valid[PC]) ? mem[PC] : HALT_INST;
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: AW=8 and AW=2 instances share stimulus and are
// checked against a program-list model of the load/fetch behaviour.
module tb_imem_loadable;

    localparam logic [8:0] HALT = 9'h1FF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [8:0] load_data = '0;
    logic       load_last = 1'b0;
    logic [7:0] pc = '0;
    logic       fetch_en = 1'b0;

    logic       rdy8, run8, full8, rdy2, run2, full2;
    logic [8:0] inst8, csum8, inst2, csum2;
    logic [8:0] plen8;
    logic [2:0] plen2;

    logic [8:0] inst_o [2];
    logic [8:0] csum_o [2];
    logic [8:0] plen_o [2];
    logic       rdy_o  [2];
    logic       run_o  [2];
    logic       full_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] pm [2][256];
    int         len [2];
    bit         loading [2];
    bit         running [2];
    logic [8:0] exp_inst [2];

    always #5 clk = ~clk;

    imem_loadable u8 (
        .CLK(clk), .reset_n(rst_n), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(rdy8), .run(run8),
        .PC(pc), .fetch_en(fetch_en), .inst(inst8),
        .prog_len(plen8), .checksum(csum8), .load_full(full8)
    );

    imem_loadable #(.AW(2)) u2 (
        .CLK(clk), .reset_n(rst_n), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(rdy2), .run(run2),
        .PC(pc[1:0]), .fetch_en(fetch_en), .inst(inst2),
        .prog_len(plen2), .checksum(csum2), .load_full(full2)
    );

    assign inst_o[0] = inst8;
    assign inst_o[1] = inst2;
    assign csum_o[0] = csum8;
    assign csum_o[1] = csum2;
    assign plen_o[0] = plen8;
    assign plen_o[1] = {6'd0, plen2};
    assign rdy_o[0]  = rdy8;
    assign rdy_o[1]  = rdy2;
    assign run_o[0]  = run8;
    assign run_o[1]  = run2;
    assign full_o[0] = full8;
    assign full_o[1] = full2;

    function automatic int depth(input int k);
        return (k == 0) ? 256 : 4;
    endfunction

    function automatic logic [8:0] exp_csum(input int k);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < len[k]; i++) c ^= pm[k][i];
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            len[k]      = 0;
            loading[k]  = 0;
            running[k]  = 0;
            exp_inst[k] = HALT;
        end
    endtask

    task automatic model_edge();
        int p;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? int'(pc) : int'(pc[1:0]);
            if (fetch_en)
                exp_inst[k] = (running[k] && p < len[k]) ? pm[k][p] : HALT;
            if (load_start) begin
                len[k]     = 0;
                loading[k] = 1;
                running[k] = 0;
            end else if (loading[k] && load_valid) begin
                pm[k][len[k]] = load_data;
                len[k]++;
                if (load_last || len[k] == depth(k)) begin
                    loading[k] = 0;
                    running[k] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [8:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pc = 8'd0;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (inst_o[0] !== HALT) begin
            n_bad++;
            $display("FAIL reset_inst got %h want %h", inst_o[0], HALT);
        end
        n_cmp++;
        if (run_o[0] !== 1'b0 || rdy_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got run=%b rdy=%b want 0/0", run_o[0], rdy_o[0]);
        end
        n_cmp++;
        if (plen_o[0] !== 9'd0 || csum_o[0] !== 9'd0 || full_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_counts got len=%0d csum=%h full=%b want 0/0/0",
                     plen_o[0], csum_o[0], full_o[0]);
        end
    endtask

    task automatic test_basic();
        logic [8:0] want [4];
        logic [8:0] held;
        want = '{9'h000, 9'h108, 9'h004, HALT};
        start_load();
        n_cmp++;
        if (rdy_o[0] !== 1'b1 || run_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_loadstate got rdy=%b run=%b want 1/0", rdy_o[0], run_o[0]);
        end
        put(9'h000, 1'b0);
        put(9'h108, 1'b0);
        put(9'h004, 1'b1);
        n_cmp++;
        if (run_o[0] !== 1'b1 || rdy_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_run got run=%b rdy=%b want 1/0", run_o[0], rdy_o[0]);
        end
        n_cmp++;
        if (plen_o[0] !== 9'd3 || csum_o[0] !== 9'h10C) begin
            n_bad++;
            $display("FAIL basic_len_csum got %0d/%h want 3/10c", plen_o[0], csum_o[0]);
        end
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            tick();
            n_cmp++;
            if (inst_o[0] !== want[i]) begin
                n_bad++;
                $display("FAIL basic_fetch pc=%0d got %h want %h", i, inst_o[0], want[i]);
            end
        end
        held = inst_o[0];
        fetch_en = 1'b0;
        pc = 8'd1;
        tick();
        n_cmp++;
        if (inst_o[0] !== held || inst_o[0] !== exp_inst[0]) begin
            n_bad++;
            $display("FAIL basic_hold got %h want %h", inst_o[0], held);
        end
    endtask

    task automatic test_toggle();
        start_load();
        for (int i = 0; i < 12; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = 9'($urandom);
            load_last  = (i == 10);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        n_cmp++;
        if (plen_o[0] !== 9'd6 || 9'(len[0]) !== 9'd6) begin
            n_bad++;
            $display("FAIL toggle_len got %0d want 6", plen_o[0]);
        end
        n_cmp++;
        if (csum_o[0] !== exp_csum(0) || run_o[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL toggle_csum got %h run=%b want %h run=1",
                     csum_o[0], run_o[0], exp_csum(0));
        end
        fetch_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pc = 8'(i);
            tick();
            n_cmp++;
            if (inst_o[0] !== exp_inst[0]) begin
                n_bad++;
                $display("FAIL toggle_fetch pc=%0d got %h want %h", i, inst_o[0], exp_inst[0]);
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_full();
        logic [8:0] csum_before;
        start_load();
        for (int i = 0; i < 4; i++) put(9'($urandom), 1'b0);
        n_cmp++;
        if (full_o[1] !== 1'b1 || run_o[1] !== 1'b1 || plen_o[1] !== 9'd4) begin
            n_bad++;
            $display("FAIL full_state got full=%b run=%b len=%0d want 1/1/4",
                     full_o[1], run_o[1], plen_o[1]);
        end
        n_cmp++;
        if (rdy_o[1] !== 1'b0 || full_o[0] !== 1'b0 || rdy_o[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL full_ready got rdy2=%b full8=%b rdy8=%b want 0/0/1",
                     rdy_o[1], full_o[0], rdy_o[0]);
        end
        csum_before = csum_o[1];
        put(9'($urandom), 1'b0);
        n_cmp++;
        if (plen_o[1] !== 9'd4 || csum_o[1] !== csum_before || csum_o[1] !== exp_csum(1)) begin
            n_bad++;
            $display("FAIL full_ignore got len=%0d csum=%h want 4/%h",
                     plen_o[1], csum_o[1], exp_csum(1));
        end
        put(9'($urandom), 1'b1);
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            tick();
            n_cmp++;
            if (inst_o[1] !== exp_inst[1]) begin
                n_bad++;
                $display("FAIL full_fetch pc=%0d got %h want %h", i, inst_o[1], exp_inst[1]);
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_restart();
        n_cmp++;
        if (run_o[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_pre got run=%b want 1", run_o[0]);
        end
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 9'h055;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        n_cmp++;
        if (run_o[0] !== 1'b0 || rdy_o[0] !== 1'b1 || plen_o[0] !== 9'd0) begin
            n_bad++;
            $display("FAIL restart_drop got run=%b rdy=%b len=%0d want 0/1/0",
                     run_o[0], rdy_o[0], plen_o[0]);
        end
        pc = 8'd0;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (inst_o[0] !== HALT) begin
            n_bad++;
            $display("FAIL restart_halt got %h want %h", inst_o[0], HALT);
        end
        put(9'h0AA, 1'b1);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (inst_o[0] !== 9'h0AA || plen_o[0] !== 9'd1) begin
            n_bad++;
            $display("FAIL restart_new got %h len=%0d want 0aa/1", inst_o[0], plen_o[0]);
        end
    endtask

    task automatic test_reset_midload();
        start_load();
        put(9'h123, 1'b0);
        put(9'h045, 1'b0);
        n_cmp++;
        if (plen_o[0] !== 9'd2) begin
            n_bad++;
            $display("FAIL midload_len got %0d want 2", plen_o[0]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (rdy_o[0] !== 1'b0 || run_o[0] !== 1'b0 || inst_o[0] !== HALT) begin
            n_bad++;
            $display("FAIL midload_async got rdy=%b run=%b inst=%h want 0/0/1ff",
                     rdy_o[0], run_o[0], inst_o[0]);
        end
        n_cmp++;
        if (plen_o[0] !== 9'd0 || csum_o[0] !== 9'd0 || full_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midload_counts got %0d/%h/%b want 0/0/0",
                     plen_o[0], csum_o[0], full_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        pc = 8'd0;
        fetch_en = 1'b1;
        put(9'h077, 1'b1);
        fetch_en = 1'b0;
        n_cmp++;
        if (inst_o[0] !== HALT || plen_o[0] !== 9'd0) begin
            n_bad++;
            $display("FAIL midload_after got %h len=%0d want 1ff/0", inst_o[0], plen_o[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            load_start = (c == 0) || ($urandom_range(0, 24) == 0);
            load_valid = $urandom_range(0, 1) == 1;
            load_last  = $urandom_range(0, 5) == 0;
            load_data  = 9'($urandom);
            fetch_en   = $urandom_range(0, 3) != 0;
            pc         = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (inst_o[k] !== exp_inst[k]) begin
                    n_bad++;
                    $display("FAIL rnd_inst[%0d] c=%0d got %h want %h", k, c, inst_o[k], exp_inst[k]);
                end
                n_cmp++;
                if (rdy_o[k] !== loading[k] || run_o[k] !== running[k]) begin
                    n_bad++;
                    $display("FAIL rnd_state[%0d] c=%0d got rdy=%b run=%b want %b/%b",
                             k, c, rdy_o[k], run_o[k], loading[k], running[k]);
                end
                n_cmp++;
                if (plen_o[k] !== 9'(len[k]) || csum_o[k] !== exp_csum(k)) begin
                    n_bad++;
                    $display("FAIL rnd_count[%0d] c=%0d got %0d/%h want %0d/%h",
                             k, c, plen_o[k], csum_o[k], len[k], exp_csum(k));
                end
                n_cmp++;
                if (full_o[k] !== (len[k] == depth(k))) begin
                    n_bad++;
                    $display("FAIL rnd_full[%0d] c=%0d got %b want %b",
                             k, c, full_o[k], len[k] == depth(k));
                end
            end
        end
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_en   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_full();
        test_restart();
        test_reset_midload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
